dmem_arbiter: RTL and testbench

Shares the single-port data memory between the CPU MEM stage (port 0) and a debug/loader master (port 1). Sequences every access through an IDLE/GRANT/DONE state machine, tolerates variable memory latency via `mem_ack_i`, and stalls the pipeline while the CPU access is outstanding. CPU has fixed priority, with an aging counter that guarantees debug progress. A cycle-accurate stall count is exported for the testbench stall statistic.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/arb_age_counter.sv | 26 ++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and port indices for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/arb_age_counter.sv
// rtl/arb_age_counter.sv - saturating count of arbitrations the debug port has lost
module arb_age_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [AW-1:0] age;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            age <= '0;
        end else if (inc && !at_limit) begin
            age <= age + 1'b1;
        end
    end

    assign at_limit = (age == AW'(STARVE_LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter sequencing accesses to the single-port data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       stall_cnt_o,
    output logic              spurious_o
);

    arb_state_e        state_q, state_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic [31:0]       stall_cnt_q;
    logic              spurious_q;
    logic              at_limit, dbg_wins, grant_start, age_inc, age_clr;

    // Debug takes the slot when it is alone or once the CPU has starved it long enough
    assign dbg_wins = dbg_req_i & (~cpu_req_i | at_limit);
    assign age_clr  = grant_start & dbg_wins;

    arb_age_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_age (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc      (age_inc),
        .clr      (age_clr),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_start = 1'b0;
        age_inc     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        cpu_ack_o   = 1'b0;
        dbg_ack_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    state_d     = GRANT;
                    grant_start = 1'b1;
                    age_inc     = cpu_req_i & dbg_req_i & ~at_limit;
                end
            end
            GRANT: begin
                mem_req_o = 1'b1;
                mem_we_o  = we_q;
                if (mem_ack_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cpu_ack_o = (owner_q == PORT_CPU);
                dbg_ack_o = (owner_q == PORT_DBG);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q     <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (grant_start) begin
                owner_q <= dbg_wins ? PORT_DBG : PORT_CPU;
                we_q    <= dbg_wins ? dbg_we_i : cpu_we_i;
                addr_q  <= dbg_wins ? dbg_addr_i : cpu_addr_i;
                wdata_q <= dbg_wins ? dbg_wdata_i : cpu_wdata_i;
            end
            if (state_q == GRANT && mem_ack_i && !we_q) begin
                if (owner_q == PORT_DBG) begin
                    dbg_rdata_q <= mem_rdata_i;
                end else begin
                    cpu_rdata_q <= mem_rdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            spurious_q  <= 1'b0;
        end else begin
            if (cpu_stall_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (mem_ack_i && state_q != GRANT) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign stall_cnt_o = stall_cnt_q;
    assign spurious_o  = spurious_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench with a transaction-level arbitration and memory model
module tb_dmem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [ADDR_W-1:0] cpu_addr_i = '0;
    logic [DATA_W-1:0] cpu_wdata_i = '0;
    logic              dbg_req_i = 1'b0, dbg_we_i = 1'b0;
    logic [ADDR_W-1:0] dbg_addr_i = '0;
    logic [DATA_W-1:0] dbg_wdata_i = '0;
    logic              mem_ack_i = 1'b0;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              cpu_ack_o, cpu_stall_o, dbg_ack_o;
    logic [DATA_W-1:0] cpu_rdata_o, dbg_rdata_o;
    logic              mem_req_o, mem_we_o, spurious_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [31:0]       stall_cnt_o;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
        .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_cnt_o(stall_cnt_o), .spurious_o(spurious_o)
    );

    always #5 clk_i = ~clk_i;

    int                checks = 0;
    int                errors = 0;
    exp_t              exp_q[$];
    logic              ack_log[$];
    logic [DATA_W-1:0] mem_model[16];
    int                losses = 0;
    logic [DATA_W-1:0] hold_cpu = '0, hold_dbg = '0;
    logic              exp_we = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_wdata = '0;
    logic [3:0]        cur_idx = '0;
    logic              in_grant = 1'b0;
    int                wait_cnt = 0;
    int                fixed_wait = 0;
    logic              mem_manual = 1'b0, rand_en = 1'b0, mon_en = 1'b0;
    logic              cpu_ack_prev = 1'b0, dbg_ack_prev = 1'b0;
    logic              s_cpu_req = 1'b0, s_cpu_we = 1'b0, s_dbg_req = 1'b0, s_dbg_we = 1'b0;
    logic [ADDR_W-1:0] s_cpu_addr = '0, s_dbg_addr = '0;
    logic [DATA_W-1:0] s_cpu_wdata = '0, s_dbg_wdata = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Memory side: decides the expected winner from the requests seen in the arbitration
    // cycle, records the expected completion, then acks after a chosen number of waits.
    task automatic respond();
        exp_t e;
        logic w;
        if (mem_manual) return;
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (!mem_req_o) begin
            in_grant = 1'b0;
            return;
        end
        if (!in_grant) begin
            if (s_cpu_req && s_dbg_req) w = (losses >= STARVE_LIMIT);
            else                        w = s_dbg_req;
            if (w)              losses = 0;
            else if (s_dbg_req) losses++;
            exp_we    = w ? s_dbg_we : s_cpu_we;
            exp_addr  = w ? s_dbg_addr : s_cpu_addr;
            exp_wdata = w ? s_dbg_wdata : s_cpu_wdata;
            cur_idx   = exp_addr[5:2];
            e.port    = w;
            if (exp_we) begin
                mem_model[cur_idx] = exp_wdata;
                e.rdata = w ? hold_dbg : hold_cpu;
            end else begin
                e.rdata = mem_model[cur_idx];
                if (w) hold_dbg = e.rdata;
                else   hold_cpu = e.rdata;
            end
            exp_q.push_back(e);
            wait_cnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            in_grant = 1'b1;
        end
        if (wait_cnt == 0) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem_model[cur_idx];
        end else begin
            wait_cnt--;
        end
    endtask

    task automatic new_cpu();
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'($urandom_range(0, 1));
        cpu_addr_i  = $urandom;
        cpu_wdata_i = $urandom;
    endtask

    task automatic new_dbg();
        dbg_req_i   = 1'b1;
        dbg_we_i    = 1'($urandom_range(0, 1));
        dbg_addr_i  = $urandom;
        dbg_wdata_i = $urandom;
    endtask

    task automatic drive_rand();
        if (cpu_req_i) begin
            if (cpu_ack_prev) begin
                if ($urandom_range(0, 1) == 0) new_cpu();
                else cpu_req_i = 1'b0;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            new_cpu();
        end
        if (dbg_req_i) begin
            if (dbg_ack_prev) begin
                if ($urandom_range(0, 2) == 0) new_dbg();
                else dbg_req_i = 1'b0;
            end
        end else if ($urandom_range(0, 4) == 0) begin
            new_dbg();
        end
        cpu_ack_prev = cpu_ack_o;
        dbg_ack_prev = dbg_ack_o;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        respond();
        if (rand_en) drive_rand();
    endtask

    task automatic zero_inputs();
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic apply_reset(input int n);
        rst_i    = 1'b1;
        losses   = 0;
        hold_cpu = '0;
        hold_dbg = '0;
        for (int i = 0; i < n; i++) begin
            cpu_req_i = 1'($urandom_range(0, 1)); cpu_we_i = 1'($urandom_range(0, 1));
            cpu_addr_i = $urandom; cpu_wdata_i = $urandom;
            dbg_req_i = 1'($urandom_range(0, 1)); dbg_we_i = 1'($urandom_range(0, 1));
            dbg_addr_i = $urandom; dbg_wdata_i = $urandom;
            mem_ack_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
            step();
        end
        rst_i = 1'b0;
        zero_inputs();
    endtask

    logic ack_due = 1'b0;
    int   stall_model = 0;
    logic spur_model = 1'b0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                check1("cpu_stall", cpu_stall_o, cpu_req_i & ~cpu_ack_o);
                check32("stall_cnt", stall_cnt_o, stall_model);
                check1("spurious", spurious_o, spur_model);
                check1("ack_timing", cpu_ack_o | dbg_ack_o, ack_due);
                if (cpu_ack_o || dbg_ack_o) begin
                    ack_log.push_back(dbg_ack_o);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: cpu_ack=%b dbg_ack=%b with nothing pending", cpu_ack_o, dbg_ack_o);
                    end else begin
                        e = exp_q.pop_front();
                        check1("ack_port_dbg", dbg_ack_o, e.port);
                        check1("ack_port_cpu", cpu_ack_o, ~e.port);
                        check32("ack_rdata", e.port ? dbg_rdata_o : cpu_rdata_o, e.rdata);
                    end
                end
                if (mem_req_o) begin
                    check1("mem_we", mem_we_o, exp_we);
                    check32("mem_addr", mem_addr_o, exp_addr);
                    check32("mem_wdata", mem_wdata_o, exp_wdata);
                end
            end
            if (rst_i) begin
                stall_model = 0;
                spur_model  = 1'b0;
                ack_due     = 1'b0;
                exp_q.delete();
            end else begin
                if (cpu_req_i && !cpu_ack_o) stall_model++;
                if (mem_ack_i && !mem_req_o) spur_model = 1'b1;
                ack_due = mem_ack_i && mem_req_o;
            end
            s_cpu_req = cpu_req_i; s_cpu_we = cpu_we_i; s_cpu_addr = cpu_addr_i; s_cpu_wdata = cpu_wdata_i;
            s_dbg_req = dbg_req_i; s_dbg_we = dbg_we_i; s_dbg_addr = dbg_addr_i; s_dbg_wdata = dbg_wdata_i;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int base;
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;

        // Reset held for two edges with random inputs
        apply_reset(2);
        check1("rst_mem_req", mem_req_o, 1'b0);
        check1("rst_mem_we", mem_we_o, 1'b0);
        check32("rst_mem_addr", mem_addr_o, 32'h0);
        check32("rst_mem_wdata", mem_wdata_o, 32'h0);
        check1("rst_cpu_ack", cpu_ack_o, 1'b0);
        check1("rst_dbg_ack", dbg_ack_o, 1'b0);
        check32("rst_cpu_rdata", cpu_rdata_o, 32'h0);
        check32("rst_dbg_rdata", dbg_rdata_o, 32'h0);
        check32("rst_stall_cnt", stall_cnt_o, 32'h0);
        check1("rst_spurious", spurious_o, 1'b0);
        check1("rst_cpu_stall", cpu_stall_o, 1'b0);
        mon_en = 1'b1;

        // CPU read of 0x0, memory returns 5 with no wait
        mem_model[0] = 32'd5;
        fixed_wait   = 0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0;
        step();
        check1("rd_req_c1", mem_req_o, 1'b1);
        check1("rd_ack_c1", cpu_ack_o, 1'b0);
        step();
        check1("rd_req_c2", mem_req_o, 1'b0);
        check1("rd_ack_c2", cpu_ack_o, 1'b1);
        check32("rd_rdata", cpu_rdata_o, 32'd5);
        cpu_req_i = 1'b0;
        step();
        check1("rd_ack_c3", cpu_ack_o, 1'b0);
        check32("rd_stall_cnt", stall_cnt_o, 32'd2);

        // DBG write of 0x1234 to 0x8 with three memory wait cycles
        fixed_wait = 3;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h8; dbg_wdata_i = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            step();
            check1("wr_req", mem_req_o, 1'b1);
            check1("wr_we", mem_we_o, 1'b1);
            check32("wr_addr", mem_addr_o, 32'h8);
            check32("wr_wdata", mem_wdata_o, 32'h1234);
            check1("wr_dbg_ack_early", dbg_ack_o, 1'b0);
        end
        step();
        check1("wr_dbg_ack", dbg_ack_o, 1'b1);
        check1("wr_cpu_ack", cpu_ack_o, 1'b0);
        dbg_req_i = 1'b0;
        step();
        check1("wr_dbg_ack_once", dbg_ack_o, 1'b0);

        // Both ports requesting continuously: debug wins every (STARVE_LIMIT+1)th slot
        fixed_wait = 0;
        ack_log.delete();
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h24;
        repeat (30) step();
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b0;
        repeat (3) step();
        check32("starve_count", ack_log.size(), 32'd10);
        for (int i = 0; i < ack_log.size() && i < 10; i++)
            check1($sformatf("starve_order_%0d", i), ack_log[i], (i % (STARVE_LIMIT + 1)) == STARVE_LIMIT);

        // Reset in the second GRANT cycle of a CPU read, then a late memory ack
        fixed_wait = 5;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h4;
        step();
        step();
        check1("abort_in_grant", mem_req_o, 1'b1);
        rst_i = 1'b1; losses = 0; hold_cpu = '0; hold_dbg = '0;
        step();
        rst_i = 1'b0;
        cpu_req_i = 1'b0;
        check1("abort_req", mem_req_o, 1'b0);
        check1("abort_ack", cpu_ack_o, 1'b0);
        check1("abort_spur_pre", spurious_o, 1'b0);
        mem_manual = 1'b1;
        mem_ack_i  = 1'b1;
        step();
        mem_ack_i  = 1'b0;
        check1("abort_spur", spurious_o, 1'b1);
        check1("abort_ack_late", cpu_ack_o, 1'b0);
        step();
        mem_manual = 1'b0;
        apply_reset(1);
        check1("spur_cleared", spurious_o, 1'b0);

        // CPU holds its request across DONE: a second access follows immediately
        fixed_wait = 0;
        base = int'(stall_cnt_o);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
        step();
        step();
        check1("hold_ack1", cpu_ack_o, 1'b1);
        cpu_addr_i = 32'h14;
        step();
        check1("hold_idle", mem_req_o, 1'b0);
        step();
        check1("hold_grant2", mem_req_o, 1'b1);
        step();
        check1("hold_ack2", cpu_ack_o, 1'b1);
        cpu_req_i = 1'b0;
        step();
        check32("hold_stall_delta", stall_cnt_o - 32'(base), 32'd4);

        // Randomized traffic with random memory latency
        fixed_wait   = -1;
        cpu_ack_prev = 1'b0;
        dbg_ack_prev = 1'b0;
        rand_en      = 1'b1;
        repeat (3000) step();
        rand_en   = 1'b0;
        cpu_req_i = 1'b0;
        dbg_req_i = 1'b0;
        for (int i = 0; i < 20 && (mem_req_o || exp_q.size() != 0); i++) step();
        step();
        check32("drain", exp_q.size(), 32'd0);
        check1("drain_idle", mem_req_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
